// File: rtl/pri_arbiter8.sv
// Eight-way highest-index-wins arbiter: grant 1 cycle after an IDLE sample, held until done/req drop/MAX_HOLD,
// one RELEASE dead cycle between owners; a timed-out owner is masked for the next arbitration only.
module pri_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       idle,
   output logic       timeout
);

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t        state, state_nxt;
   logic [2:0]    owner, owner_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [7:0]    mask, mask_nxt;
   logic [7:0]    gnt_nxt;
   logic [2:0]    gnt_id_nxt;
   logic          gnt_valid_nxt;
   logic          timeout_nxt;
   logic [7:0]    eff;
   logic [2:0]    pick;
   logic          rel_vol;

   always_comb begin
      eff = req & ~mask;
      // The mask only redirects a grant; it never blocks a lone requester.
      if (eff == 8'd0) eff = req;
      pick = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eff[i]) pick = 3'(i);
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      cnt_nxt       = cnt;
      mask_nxt      = mask;
      gnt_nxt       = gnt;
      gnt_id_nxt    = gnt_id;
      gnt_valid_nxt = gnt_valid;
      timeout_nxt   = 1'b0;
      rel_vol       = done || !req[owner];
      case (state)
         IDLE: begin
            if (en && (eff != 8'd0)) begin
               state_nxt     = GRANT;
               owner_nxt     = pick;
               cnt_nxt       = '0;
               mask_nxt      = 8'd0;
               gnt_nxt       = 8'd1 << pick;
               gnt_id_nxt    = pick;
               gnt_valid_nxt = 1'b1;
            end
         end
         GRANT: begin
            if (rel_vol || (cnt == LIM)) begin
               state_nxt     = RELEASE;
               gnt_nxt       = 8'd0;
               gnt_id_nxt    = 3'd0;
               gnt_valid_nxt = 1'b0;
               // Voluntary release in the limit cycle wins: no pulse, no mask.
               if (!rel_vol) begin
                  timeout_nxt = 1'b1;
                  mask_nxt    = 8'd1 << owner;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 3'd0;
         cnt       <= '0;
         mask      <= 8'd0;
         gnt       <= 8'd0;
         gnt_id    <= 3'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         cnt       <= cnt_nxt;
         mask      <= mask_nxt;
         gnt       <= gnt_nxt;
         gnt_id    <= gnt_id_nxt;
         gnt_valid <= gnt_valid_nxt;
         timeout   <= timeout_nxt;
      end
   end

   assign idle = en && (req == 8'd0) && (state == IDLE);

endmodule

// File: tb/tb_pri_arbiter8.sv
// Directed-vector bench for pri_arbiter8 with MAX_HOLD=4; expected values worked out by hand.
module tb_pri_arbiter8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       idle;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   pri_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .idle      (idle),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bring the arbiter back to IDLE with no requests pending.
   task automatic settle();
      req  = 8'd0;
      done = 1'b0;
      en   = 1'b1;
      step(3);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'd0;
      done  = 1'b0;
      #12;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_gnt_id", 32'(gnt_id), 32'h0);
      check("rst_gnt_valid", 32'(gnt_valid), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      check("rst_idle_en0", 32'(idle), 32'h0);
      en = 1'b1;
      #1;
      check("rst_idle_en1", 32'(idle), 32'h1);
      rst_n = 1'b1;
      step(1);

      // Priority: bit 5 beats bits 2 and 1, then bit 2 after the hand-off gap
      req = 8'b0010_0110;
      step(1);
      check("pri_gnt5", 32'(gnt), 32'h20);
      check("pri_id5", 32'(gnt_id), 32'd5);
      check("pri_valid", 32'(gnt_valid), 32'h1);
      done = 1'b1;
      req  = 8'b0000_0110;
      step(1);
      done = 1'b0;
      check("pri_gap1", 32'(gnt), 32'h0);
      check("pri_gap1_valid", 32'(gnt_valid), 32'h0);
      step(1);
      check("pri_gap2", 32'(gnt), 32'h0);
      step(1);
      check("pri_gnt2", 32'(gnt), 32'h04);
      check("pri_id2", 32'(gnt_id), 32'd2);
      done = 1'b1;
      settle();

      // Enable gating
      en  = 1'b0;
      req = 8'h81;
      step(3);
      check("en0_gnt", 32'(gnt), 32'h0);
      check("en0_idle", 32'(idle), 32'h0);
      en  = 1'b1;
      req = 8'h00;
      #1;
      check("en1_req0_idle", 32'(idle), 32'h1);
      req = 8'h08;
      #1;
      check("idle_req_high", 32'(idle), 32'h0);
      step(1);
      check("en_gnt3", 32'(gnt), 32'h08);
      en = 1'b0;
      step(2);
      check("en_drop_hold", 32'(gnt), 32'h08);
      check("en_drop_id", 32'(gnt_id), 32'd3);
      done = 1'b1;
      step(1);
      check("en_drop_done", 32'(gnt), 32'h0);
      settle();

      // Timeout on 0x80, masked once so 0x01 gets the next grant
      req = 8'h81;
      step(1);
      check("to_c1", 32'(gnt), 32'h80);
      step(1);
      check("to_c2", 32'(gnt), 32'h80);
      step(1);
      check("to_c3", 32'(gnt), 32'h80);
      step(1);
      check("to_c4", 32'(gnt), 32'h80);
      check("to_c4_nopulse", 32'(timeout), 32'h0);
      step(1);
      check("to_rel_gnt", 32'(gnt), 32'h0);
      check("to_pulse", 32'(timeout), 32'h1);
      step(1);
      check("to_idle_gnt", 32'(gnt), 32'h0);
      check("to_pulse_end", 32'(timeout), 32'h0);
      step(1);
      check("mask_gnt0", 32'(gnt), 32'h01);
      check("mask_id0", 32'(gnt_id), 32'd0);
      req = 8'h80;
      step(3);
      check("mask_cleared", 32'(gnt), 32'h80);
      check("mask_cleared_id", 32'(gnt_id), 32'd7);
      done = 1'b1;
      settle();

      // Lone requester is never blocked by its own mask
      req = 8'h40;
      step(4);
      check("lone_c4", 32'(gnt), 32'h40);
      step(1);
      check("lone_pulse", 32'(timeout), 32'h1);
      check("lone_gap1", 32'(gnt), 32'h0);
      step(1);
      check("lone_gap2", 32'(gnt), 32'h0);
      step(1);
      check("lone_regrant", 32'(gnt), 32'h40);
      done = 1'b1;
      settle();

      // done in the limit cycle: no pulse and no mask on bit 4
      req = 8'h10;
      step(4);
      check("sim_c4", 32'(gnt), 32'h10);
      done = 1'b1;
      req  = 8'h11;
      step(1);
      done = 1'b0;
      check("sim_no_pulse", 32'(timeout), 32'h0);
      check("sim_rel_gnt", 32'(gnt), 32'h0);
      step(2);
      check("sim_no_mask", 32'(gnt), 32'h10);
      check("sim_no_mask_id", 32'(gnt_id), 32'd4);
      done = 1'b1;
      settle();

      // Async reset mid-grant
      req = 8'h02;
      step(2);
      check("ar_pre", 32'(gnt), 32'h02);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_gnt", 32'(gnt), 32'h0);
      check("ar_valid", 32'(gnt_valid), 32'h0);
      check("ar_timeout", 32'(timeout), 32'h0);
      #1;
      rst_n = 1'b1;
      step(1);
      check("ar_regrant", 32'(gnt), 32'h02);
      check("ar_regrant_id", 32'(gnt_id), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pri_arbiter8.md
# pri_arbiter8

Eight-requester arbiter that shares one downstream resource using the team's highest-index-wins priority rule (req[7] highest, req[0] lowest). It samples requests, grants one owner, holds the grant until release or timeout, and inserts one dead cycle between owners. A one-shot mask after a timeout stops a single high-priority requester from starving the rest. It sits between the request sources and the shared datapath, and its en/idle behaviour matches the ei/eo cascade semantics used by the priority encoders.

## Interface
- MAX_HOLD, 16: maximum cycles a grant may be held before forced release; legal range 2..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable; gates new grants only.
- req  in  8  request vector, level-sensitive; bit 7 has the highest priority.
- done  in  1  current owner releases the resource; ignored outside GRANT.
- gnt  out  8  one-hot grant, or all zeros.
- gnt_id  out  3  index of the current owner; 0 when no grant.
- gnt_valid  out  1  high exactly when gnt is non-zero.
- idle  out  1  high when en=1, req=0 and the FSM is in IDLE.
- timeout  out  1  one-cycle pulse when a grant is force-released.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - Compute eff = req & ~mask.
  - If eff=0 while req≠0, use eff = req (the mask never blocks a lone requester).
  - If en=1 and eff≠0, latch owner = highest set bit of eff and go to GRANT.
  - Clear mask at the moment of that transition.
- GRANT:
  - gnt = 1<<owner, gnt_id = owner, gnt_valid = 1.
  - Hold counter starts at 0 on entry and increments each cycle.
  - Exit to RELEASE on any of:
    - done=1;
    - req[owner]=0;
    - counter = MAX_HOLD-1.
  - Timeout case: the counter limit is reached and neither done nor req[owner] dropped that cycle. Only then pulse timeout (registered, asserted during the first RELEASE cycle) and set mask = 1<<owner.
  - Voluntary release wins over timeout in the same cycle: no pulse, no mask.
- RELEASE:
  - Lasts exactly one cycle; gnt=0, gnt_valid=0; then IDLE.
  - No request is sampled during RELEASE.
- en=0 never revokes a grant already given; it only blocks the IDLE→GRANT transition.
- Holding done=1 in IDLE or RELEASE has no effect.
- Counter width: $clog2(MAX_HOLD). Counter saturation is unreachable, because the counter always exits at MAX_HOLD-1.

## Timing
- Reset (async, immediate): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, mask=0, counter=0. idle then follows its combinational definition.
- All outputs are registered from state except idle, which is combinational from en, req and state.
- Grant latency: req sampled high in IDLE at edge N gives gnt high in cycle N+1.
- Minimum grant length is 1 cycle: done is high on the first GRANT cycle.
- Maximum grant length is MAX_HOLD cycles.
- Hand-off between owners costs one RELEASE cycle, plus one IDLE sampling cycle, so there are 2 cycles with gnt=0 between consecutive grants.
- A requester that drops req does not lose priority; it re-arbitrates normally.
- Reset asserted mid-GRANT: gnt drops asynchronously that same instant. After reset deasserts, the first grant follows one IDLE sample.

## Test plan
- Priority: en=1, req=8'b0010_0110 → gnt=8'b0010_0000, gnt_id=5 one cycle later. Then done=1 → 2 idle cycles → gnt=8'b0000_0100, gnt_id=2.
- Enable gating:
  - en=0, req=8'h81 → gnt stays 0, idle=0, no grant.
  - en=1, req=0 → idle=1.
  - Drop en mid-grant → grant persists until done.
- Timeout and mask:
  - MAX_HOLD=4, req=8'h81 held, no done → gnt=8'h80 for exactly 4 cycles, then timeout pulses 1 cycle, then gnt=8'h01.
  - req[0] then drops → next grant is 8'h80 again (mask cleared).
- Lone requester: MAX_HOLD=4, req=8'h40 held → timeout, then after 2 gap cycles gnt=8'h40 again (mask does not block a sole requester).
- Simultaneous exit: done=1 on cycle MAX_HOLD of a grant → RELEASE with timeout=0 and no mask applied.
- Async reset: assert rst_n=0 mid-grant between clock edges → gnt=0, gnt_valid=0, timeout=0 immediately. After release with req=8'h02 → gnt=8'h02 after one cycle.
